// File: rtl/gen_debounce.sv
// Per-bit debounce filter with registered level, rise/fall pulses and optional
// sticky interrupt pending bits (enabled by GEN_DEBOUNCE_IRQ_EN).
module gen_debounce #(
  parameter int  DW     = 32,
  parameter int  DB_CNT = 16,
  localparam int CW     = (DB_CNT > 1) ? $clog2(DB_CNT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall,
  input  logic [DW-1:0] irq_clr,
  output logic          irq
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

  logic [CW-1:0] cnt      [DW];
  logic [CW-1:0] cnt_nxt  [DW];
  logic [DW-1:0] dout_nxt;
  logic [DW-1:0] rise_nxt;
  logic [DW-1:0] fall_nxt;

  // Terminal compare precedes the increment, so the counter never wraps.
  always_comb begin
    dout_nxt = dout;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < DW; i++) begin
      cnt_nxt[i] = cnt[i];
      if (din[i] == dout[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_MAX) begin
          dout_nxt[i] = din[i];
          cnt_nxt[i]  = '0;
          rise_nxt[i] = din[i];
          fall_nxt[i] = ~din[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < DW; i++) cnt[i] <= '0;
    end else begin
      dout <= dout_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
      for (int i = 0; i < DW; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`ifdef GEN_DEBOUNCE_IRQ_EN
  logic [DW-1:0] pend;

  // Set from the registered pulses, so a simultaneous clear loses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~irq_clr) | rise | fall;
  end

  assign irq = |pend;
`else
  assign irq = 1'b0 & (|irq_clr);
`endif

endmodule

// File: tb/tb_gen_debounce.sv
// Directed bench for gen_debounce: one DB_CNT=4 instance and one DB_CNT=1 instance.
module tb_gen_debounce;

`ifdef GEN_DEBOUNCE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] a_din, a_dout, a_rise, a_fall, a_irq_clr;
  logic       a_irq;
  logic [3:0] b_din, b_dout, b_rise, b_fall;
  logic       b_irq;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gen_debounce #(.DW(4), .DB_CNT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .din(a_din), .dout(a_dout),
    .rise(a_rise), .fall(a_fall), .irq_clr(a_irq_clr), .irq(a_irq)
  );

  gen_debounce #(.DW(4), .DB_CNT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .din(b_din), .dout(b_dout),
    .rise(b_rise), .fall(b_fall), .irq_clr(4'b0000), .irq(b_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply tick for one edge, then sample 1 time unit after it.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[5];
    seq = '{1, 0, 1, 1, 0};
    rst_n = 1'b0; tick = 1'b1;
    a_din = '0; b_din = '0; a_irq_clr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_dout", a_dout, 0);
    chk("rst_a_rise", a_rise, 0);
    chk("rst_a_fall", a_fall, 0);
    chk("rst_a_irq", a_irq, 0);
    chk("rst_b_dout", b_dout, 0);
    chk("rst_b_irq", b_irq, 0);
    rst_n = 1'b1;

    // Press: dout[0] rises on the 4th edge
    a_din = 4'b0001;
    repeat (3) cyc(1'b1);
    chk("press_pre_dout", a_dout, 4'b0000);
    chk("press_pre_rise", a_rise, 4'b0000);
    cyc(1'b1);
    chk("press_dout", a_dout, 4'b0001);
    chk("press_rise", a_rise, 4'b0001);
    chk("press_fall", a_fall, 4'b0000);
    cyc(1'b1);
    chk("press_rise_1cyc", a_rise, 4'b0000);
    chk("press_dout_hold", a_dout, 4'b0001);

    // Release with tick every 3rd cycle: fall on the 12th edge
    a_din = 4'b0000;
    for (int k = 1; k <= 11; k++) cyc(k % 3 == 0);
    chk("rel_pre_dout", a_dout, 4'b0001);
    chk("rel_pre_fall", a_fall, 4'b0000);
    cyc(1'b1);
    chk("rel_dout", a_dout, 4'b0000);
    chk("rel_fall", a_fall, 4'b0001);
    chk("rel_rise", a_rise, 4'b0000);
    cyc(1'b1);
    chk("rel_fall_1cyc", a_fall, 4'b0000);

    // Bounce 1,0,1,1,0 then hold 1
    for (int k = 0; k < 5; k++) begin
      a_din = {3'b000, seq[k][0]};
      cyc(1'b1);
      chk("bnc_dout", a_dout, 4'b0000);
      chk("bnc_pulse", {a_rise, a_fall}, 8'h00);
    end
    a_din = 4'b0001;
    repeat (3) cyc(1'b1);
    chk("bnc_pre_dout", a_dout, 4'b0000);
    cyc(1'b1);
    chk("bnc_dout_final", a_dout, 4'b0001);
    chk("bnc_rise", a_rise, 4'b0001);

    // Reset asserted mid-count restarts the full count
    rst_n = 1'b0;
    #1;
    chk("mr_async_dout", a_dout, 4'b0000);
    chk("mr_async_rise", a_rise, 4'b0000);
    cyc(1'b1);
    rst_n = 1'b1;
    repeat (2) cyc(1'b1);
    chk("mr_half_dout", a_dout, 4'b0000);
    rst_n = 1'b0;
    #1;
    chk("mr_mid_pulse", {a_rise, a_fall}, 8'h00);
    cyc(1'b1);
    rst_n = 1'b1;
    repeat (3) cyc(1'b1);
    chk("mr_3_dout", a_dout, 4'b0000);
    chk("mr_3_rise", a_rise, 4'b0000);
    cyc(1'b1);
    chk("mr_4_dout", a_dout, 4'b0001);
    chk("mr_4_rise", a_rise, 4'b0001);

    // Interrupt pending: set on pulse one cycle later, clear, set-wins
    cyc(1'b1);
    chk("irq_after_rise0", a_irq, IRQ_ON);
    a_irq_clr = 4'b1111;
    cyc(1'b1);
    a_irq_clr = 4'b0000;
    chk("irq_cleared", a_irq, 0);
    a_din = 4'b0101;
    repeat (4) cyc(1'b1);
    chk("irq_rise2", a_rise, 4'b0100);
    chk("irq_not_yet", a_irq, 0);
    cyc(1'b1);
    chk("irq_set", a_irq, IRQ_ON);
    a_din = 4'b0001;
    repeat (4) cyc(1'b1);
    chk("irq_fall2", a_fall, 4'b0100);
    a_irq_clr = 4'b0100;
    cyc(1'b1);
    a_irq_clr = 4'b0000;
    chk("irq_set_wins", a_irq, IRQ_ON);
    a_irq_clr = 4'b0100;
    cyc(1'b1);
    a_irq_clr = 4'b0000;
    chk("irq_clear_alone", a_irq, 0);

    // DB_CNT=1: one-register delay with edge detect
    b_din = 4'b1010;
    cyc(1'b1);
    b_din = 4'b0000;
    chk("b_dout", b_dout, 4'b1010);
    chk("b_rise", b_rise, 4'b1010);
    chk("b_fall0", b_fall, 4'b0000);
    cyc(1'b1);
    chk("b_dout_back", b_dout, 4'b0000);
    chk("b_fall", b_fall, 4'b1010);
    chk("b_rise0", b_rise, 4'b0000);
    cyc(1'b1);
    chk("b_fall_1cyc", b_fall, 4'b0000);
    chk("b_irq", b_irq, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
